// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch sequencer states (IDLE, REQ, HOLD, HALTED)
//   FETCH_CNT_W   : width of the optional retired-fetch counter
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    localparam int FETCH_CNT_W = 32;

endpackage : fetch_pkg

// File: rtl/fetch_perf_counter.sv
// -----------------------------------------------------------------------------
// fetch_perf_counter
// Saturating event counter. It counts one per cycle with inc high, sticks at
// all-ones and is cleared only by reset.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   inc    in   count this cycle
//   count  out  CNT_W-bit counter value
// -----------------------------------------------------------------------------
module fetch_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : fetch_perf_counter

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction fetch stage. It owns the program counter (fetch_pc) and the
// instruction register. It runs a request/ready handshake to instruction memory
// with variable latency. Each fetched word goes to the controller over a
// valid/ack handshake. The controller can take a branch or halt when it acks.
//
// Optional feature: define FETCH_PERF_EN to add the fetch_count port and a
// saturating counter of acked instructions.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, start_pc   begin fetching at start_pc (honoured in IDLE/HALTED only)
//   mem_req, mem_addr fetch request and address (mem_addr == fetch_pc)
//   mem_ready         mem_rdata holds the requested word this cycle
//   mem_rdata         instruction word from memory
//   ir, ir_valid      instruction register and its valid flag
//   ir_ack            controller consumes ir
//   pc                address of the instruction held in ir
//   redirect(_pc)     branch taken and its target, sampled with ir_ack
//   halt              stop after this instruction, sampled with ir_ack
//   waiting, halted   status: in IDLE / in HALTED
//   fetch_count       acked-instruction count (FETCH_PERF_EN only)
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_pc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               ir_ack,
    output logic [ADDR_W-1:0]  pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               waiting,
`ifdef FETCH_PERF_EN
    output logic               halted,
    output logic [FETCH_CNT_W-1:0] fetch_count
`else
    output logic               halted
`endif
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_REQ    = REQ;
    localparam logic [1:0] S_HOLD   = HOLD;
    localparam logic [1:0] S_HALTED = HALTED;

    logic [1:0]        state;
    logic [ADDR_W-1:0] fetch_pc;

    // All status outputs come from the state register alone. Reset therefore
    // drops mem_req and ir_valid at once, with no input-to-output path.
    assign mem_req  = (state == S_REQ);
    assign ir_valid = (state == S_HOLD);
    assign waiting  = (state == S_IDLE);
    assign halted   = (state == S_HALTED);
    assign mem_addr = fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            pc       <= RESET_PC;
            ir       <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        fetch_pc <= start_pc;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        ir       <= mem_rdata;
                        pc       <= fetch_pc;
                        // Natural wrap: all-ones rolls over to zero.
                        fetch_pc <= fetch_pc + ADDR_W'(1);
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ir_ack) begin
                        // halt takes priority over a simultaneous branch.
                        if (halt) begin
                            state <= S_HALTED;
                        end else begin
                            if (redirect) begin
                                fetch_pc <= redirect_pc;
                            end
                            state <= S_REQ;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    fetch_perf_counter #(
        .CNT_W (FETCH_CNT_W)
    ) u_perf (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ir_valid & ir_ack),
        .count (fetch_count)
    );
`endif

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Bench for instr_fetch_unit with a transaction-level reference model.
// It also drives a small stand-alone fetch_perf_counter to reach saturation.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  start_pc;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ack;
    logic [7:0]  pc;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halt;
    logic        waiting;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
`endif

    logic        sat_inc;
    logic [3:0]  sat_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (16),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_pc    (start_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .ir_ack      (ir_ack),
        .pc          (pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .waiting     (waiting),
`ifdef FETCH_PERF_EN
        .halted      (halted),
        .fetch_count (fetch_count)
`else
        .halted      (halted)
`endif
    );

    fetch_perf_counter #(.CNT_W(4)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sat_inc),
        .count (sat_count)
    );

    // Reference model. "running" means the program is active (fetching or
    // holding). "have_instr" means an unconsumed instruction is held.
    bit          m_running;
    bit          m_have_instr;
    bit          m_stopped;
    int unsigned m_next_addr;
    int unsigned m_ir;
    int unsigned m_pc;
    longint unsigned m_count;
    int unsigned m_sat;

    task automatic model_reset();
        m_running    = 0;
        m_have_instr = 0;
        m_stopped    = 0;
        m_next_addr  = 0;
        m_ir         = 0;
        m_pc         = 0;
        m_count      = 0;
        m_sat        = 0;
    endtask

    // Apply the inputs present at this rising edge.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (sat_inc && m_sat < 15) m_sat++;
        if (!m_running) begin
            if (start) begin
                m_next_addr = start_pc;
                m_running   = 1;
                m_stopped   = 0;
            end
        end else if (!m_have_instr) begin
            if (mem_ready) begin
                m_ir         = mem_rdata;
                m_pc         = m_next_addr;
                m_next_addr  = (m_next_addr + 1) % 256;
                m_have_instr = 1;
            end
        end else if (ir_ack) begin
            m_have_instr = 0;
            if (m_count < 64'hFFFF_FFFF) m_count++;
            if (halt) begin
                m_running = 0;
                m_stopped = 1;
            end else if (redirect) begin
                m_next_addr = redirect_pc;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("mem_req",  32'(mem_req),  32'(m_running && !m_have_instr));
        check("ir_valid", 32'(ir_valid), 32'(m_have_instr));
        check("waiting",  32'(waiting),  32'(!m_running && !m_stopped));
        check("halted",   32'(halted),   32'(m_stopped));
        check("mem_addr", 32'(mem_addr), m_next_addr);
        check("ir",       32'(ir),       m_ir);
        check("pc",       32'(pc),       m_pc);
        check("sat_count", 32'(sat_count), m_sat);
`ifdef FETCH_PERF_EN
        check("fetch_count", fetch_count, 32'(m_count));
`endif
    endtask

    // One clock: model follows the edge, outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic quiet_inputs();
        start       = 0;
        start_pc    = 8'h00;
        mem_ready   = 0;
        mem_rdata   = 16'h0000;
        ir_ack      = 0;
        redirect    = 0;
        redirect_pc = 8'h00;
        halt        = 0;
        sat_inc     = 0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst_n = 0;
        model_reset();
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        quiet_inputs();
        model_reset();
        #2;
        step();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_waiting", 32'(waiting), 32'd1);
        check("rst_ir",      32'(ir),      32'd0);
        check("rst_pc",      32'(pc),      32'd0);
        check("rst_addr",    32'(mem_addr), 32'd0);
        step();
        rst_n = 1;

        // Start at 0x10, zero-wait memory.
        start = 1; start_pc = 8'h10;
        step();
        start = 0;
        check("start_req",  32'(mem_req),  32'd1);
        check("start_addr", 32'(mem_addr), 32'h10);
        mem_ready = 1; mem_rdata = 16'hA001;
        step();
        mem_ready = 0; mem_rdata = 16'hDEAD;
        check("first_ir",    32'(ir),       32'hA001);
        check("first_pc",    32'(pc),       32'h10);
        check("first_valid", 32'(ir_valid), 32'd1);

        // Ack, then three wait states before the word arrives.
        ir_ack = 1;
        step();
        ir_ack = 0;
        for (int i = 0; i < 3; i++) begin
            mem_rdata = 16'($urandom);
            step();
            check("wait_req",  32'(mem_req),  32'd1);
            check("wait_addr", 32'(mem_addr), 32'h11);
            check("wait_ir",   32'(ir),       32'hA001);
        end
        mem_ready = 1; mem_rdata = 16'h1234;
        step();
        mem_ready = 0;
        check("wait_ir_load", 32'(ir), 32'h1234);
        check("wait_pc_load", 32'(pc), 32'h11);

        // start while holding is ignored.
        start = 1; start_pc = 8'h77;
        step();
        start = 0;
        check("hold_start_valid", 32'(ir_valid), 32'd1);

        // Ack with a branch.
        ir_ack = 1; redirect = 1; redirect_pc = 8'h40;
        step();
        ir_ack = 0; redirect = 0;
        check("redir_addr", 32'(mem_addr), 32'h40);

        // Fetch, then ack with halt and redirect together.
        mem_ready = 1; mem_rdata = 16'h5555;
        step();
        mem_ready = 0;
        ir_ack = 1; halt = 1; redirect = 1; redirect_pc = 8'h99;
        step();
        ir_ack = 0; halt = 0; redirect = 0;
        check("halt_halted", 32'(halted),  32'd1);
        check("halt_req",    32'(mem_req), 32'd0);
        mem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_noreq", 32'(mem_req), 32'd0);
        end
        mem_ready = 0;

        // Restart from HALTED at 0x20.
        start = 1; start_pc = 8'h20;
        step();
        start = 0;
        check("restart_addr",   32'(mem_addr), 32'h20);
        check("restart_halted", 32'(halted),   32'd0);

        // Wrap: branch to 0xFF, fetch it, sequential ack goes to 0x00.
        mem_ready = 1;
        step();
        mem_ready = 0;
        ir_ack = 1; redirect = 1; redirect_pc = 8'hFF;
        step();
        ir_ack = 0; redirect = 0;
        check("wrap_ff", 32'(mem_addr), 32'hFF);
        mem_ready = 1;
        step();
        mem_ready = 0;
        check("wrap_pc", 32'(pc), 32'hFF);
        ir_ack = 1;
        step();
        ir_ack = 0;
        check("wrap_00", 32'(mem_addr), 32'h00);

        // Asynchronous reset while requesting; a late mem_ready is discarded.
        #3;
        rst_n = 0;
        #1;
        model_reset();
        check("arst_req",     32'(mem_req),  32'd0);
        check("arst_valid",   32'(ir_valid), 32'd0);
        check("arst_waiting", 32'(waiting),  32'd1);
        mem_ready = 1; mem_rdata = 16'hBEEF;
        step();
        rst_n = 1;
        mem_ready = 0;
        step();
        check("arst_late_ir",  32'(ir),      32'd0);
        check("arst_late_req", 32'(mem_req), 32'd0);

        // Five acked instructions from a clean reset.
        do_reset();
        start = 1; start_pc = 8'h30;
        step();
        start = 0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1; mem_rdata = 16'($urandom);
            step();
            mem_ready = 0; ir_ack = 1;
            step();
            ir_ack = 0;
        end
        check("five_next_addr", 32'(mem_addr), 32'h35);
`ifdef FETCH_PERF_EN
        check("five_count", fetch_count, 32'd5);
`endif

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            start       = ($urandom_range(7) == 0);
            start_pc    = 8'($urandom);
            mem_ready   = ($urandom_range(2) != 0);
            mem_rdata   = 16'($urandom);
            ir_ack      = ($urandom_range(1) == 1);
            redirect    = ($urandom_range(2) == 0);
            redirect_pc = 8'($urandom);
            halt        = ($urandom_range(15) == 0);
            sat_inc     = ($urandom_range(3) == 0);
            step();
        end

        // Saturating counter: from reset, count past the 4-bit limit.
        do_reset();
        sat_inc = 1;
        for (int i = 0; i < 20; i++) step();
        sat_inc = 0;
        check("sat_hold", 32'(sat_count), 32'hF);
        step();
        check("sat_stay", 32'(sat_count), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instr_fetch_unit
